// File: rtl/bit_serializer_pkg.sv
// Types and defaults shared by the serializer and the sequence-detector bench.
// The defaults match the detector chain: 8-bit words with an idle-low line.
package bit_serializer_pkg;

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  localparam int   DEF_WORD_W   = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;
  localparam int   DEF_CNT_W    = 16;

  // Bit-index width.
  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word handshake and serial-line bundle for bit_serializer.
// The master side produces words. The slave side is the serializer itself.
interface bit_serializer_if #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
);
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              bit_out;
  logic              bit_valid;
  logic              frame_start;
  logic              busy;
  logic [CNT_W-1:0]  words_sent;

  modport master (
    output word_in, word_valid,
    input  word_ready, bit_out, bit_valid, frame_start, busy, words_sent
  );

  modport slave (
    input  word_in, word_valid,
    output word_ready, bit_out, bit_valid, frame_start, busy, words_sent
  );
endinterface

// File: rtl/bit_serializer.sv
// Serializes parallel words onto a single bit line, one bit per clock.
// A one-word hold register keeps back-to-back words gap-free.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int   WORD_W    = DEF_WORD_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEF_IDLE_BIT,
  parameter int   CNT_W     = DEF_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  bit_serializer_if.slave bus
);

  localparam int              IDX_W    = idx_w(WORD_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  ser_state_t        state_q, state_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              hold_full_q, hold_full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              accept;
  logic              last_bit;
  logic              shifter_free;
  logic [WORD_W-1:0] sh_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      hold_full_q <= hold_full_d;
      cnt_q       <= cnt_d;
    end
  end

  // The current bit always sits at the outgoing end of sh.
  // This avoids an idx-driven mux on bit_out.
  always_comb begin
    sh_next = sh_q;
    if (MSB_FIRST) sh_next = {sh_q[WORD_W-2:0], 1'b0};
    else           sh_next = {1'b0, sh_q[WORD_W-1:1]};
  end

  always_comb begin
    accept       = bus.word_valid && !hold_full_q;
    last_bit     = (state_q == SHIFT) && (idx_q == LAST_IDX);
    shifter_free = (state_q == IDLE) || last_bit;

    state_d     = state_q;
    sh_d        = (state_q == SHIFT) ? sh_next : sh_q;
    idx_d       = (state_q == SHIFT) ? idx_q + IDX_W'(1) : idx_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    cnt_d       = cnt_q + CNT_W'(last_bit);

    if (shifter_free) begin
      if (hold_full_q) begin
        sh_d        = hold_q;
        idx_d       = '0;
        hold_full_d = 1'b0;
        state_d     = SHIFT;
      end else if (accept) begin
        sh_d    = bus.word_in;
        idx_d   = '0;
        state_d = SHIFT;
      end else begin
        idx_d   = '0;
        state_d = IDLE;
      end
    end else if (accept) begin
      hold_d      = bus.word_in;
      hold_full_d = 1'b1;
    end
  end

  assign bus.word_ready  = !hold_full_q;
  assign bus.bit_valid   = (state_q == SHIFT);
  assign bus.bit_out     = (state_q == SHIFT) ? (MSB_FIRST ? sh_q[WORD_W-1] : sh_q[0]) : IDLE_BIT;
  assign bus.frame_start = (state_q == SHIFT) && (idx_q == '0);
  assign bus.busy        = (state_q == SHIFT) || hold_full_q;
  assign bus.words_sent  = cnt_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Randomized and directed checks of bit_serializer against a word-queue model.
// Two instances: MSB-first/idle-low/16-bit count, and LSB-first/idle-high/4-bit count.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit_serializer_if #(.WORD_W(W), .CNT_W(16)) b0 ();
  bit_serializer_if #(.WORD_W(W), .CNT_W(4))  b1 ();

  bit_serializer #(.WORD_W(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  bit_serializer #(.WORD_W(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .bus(b1));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: rem = bits still to emit of the current word (0 = idle).
  // The pending flag/word stand for a word accepted while the line was busy.
  int         rem[2]  = '{0, 0};
  int         sent[2] = '{0, 0};
  bit         pv[2]   = '{1'b0, 1'b0};
  logic [W-1:0] cur[2];
  logic [W-1:0] pw[2];
  bit         msbf[2]  = '{1'b1, 1'b0};
  bit         idleb[2] = '{1'b0, 1'b1};
  int         mask[2]  = '{32'hFFFF, 32'hF};

  task automatic mstep(input int i, input logic v, input logic [W-1:0] w);
    bit acc;
    acc = v && !pv[i];
    if (rem[i] > 0) begin
      rem[i]--;
      if (rem[i] == 0) sent[i]++;
    end
    if (rem[i] == 0) begin
      if (pv[i]) begin
        cur[i] = pw[i]; rem[i] = W; pv[i] = 1'b0;
      end else if (acc) begin
        cur[i] = w; rem[i] = W; acc = 1'b0;
      end
    end
    if (acc) begin
      pv[i] = 1'b1; pw[i] = w;
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        rem[i] = 0; pv[i] = 1'b0; sent[i] = 0;
      end
    end else begin
      mstep(0, b0.word_valid, b0.word_in);
      mstep(1, b1.word_valid, b1.word_in);
    end
  end

  task automatic cmp(input int i, input logic rdy, input logic bo, input logic bv,
                     input logic fs, input logic bsy, input logic [15:0] ws);
    logic ebo;
    if (rem[i] > 0) ebo = msbf[i] ? cur[i][rem[i]-1] : cur[i][W-rem[i]];
    else            ebo = idleb[i];
    chk($sformatf("d%0d.bit_out", i),     32'(bo),  32'(ebo));
    chk($sformatf("d%0d.bit_valid", i),   32'(bv),  32'(rem[i] > 0));
    chk($sformatf("d%0d.frame_start", i), 32'(fs),  32'(rem[i] == W));
    chk($sformatf("d%0d.busy", i),        32'(bsy), 32'(rem[i] > 0 || pv[i]));
    chk($sformatf("d%0d.word_ready", i),  32'(rdy), 32'(!pv[i]));
    chk($sformatf("d%0d.words_sent", i),  32'(ws),  32'(sent[i] & mask[i]));
  endtask

  bit         seen15 = 1'b0;
  bit         seenwrap = 1'b0;
  logic [3:0] prev1 = 4'd0;

  initial forever begin
    @(negedge clk);
    cmp(0, b0.word_ready, b0.bit_out, b0.bit_valid, b0.frame_start, b0.busy, b0.words_sent);
    cmp(1, b1.word_ready, b1.bit_out, b1.bit_valid, b1.frame_start, b1.busy, 16'(b1.words_sent));
    if (b1.words_sent == 4'd15) seen15 = 1'b1;
    if (prev1 == 4'd15 && b1.words_sent == 4'd0) seenwrap = 1'b1;
    prev1 = b1.words_sent;
  end

  // Called at a negedge; returns at the negedge of the first cycle after the accept edge.
  task automatic send0(input logic [W-1:0] w);
    int n = 0;
    b0.word_in = w; b0.word_valid = 1'b1;
    while (!b0.word_ready && n < 100) begin @(negedge clk); n++; end
    chk("send0.ready", 32'(b0.word_ready), 32'd1);
    @(negedge clk);
    b0.word_valid = 1'b0;
  endtask

  task automatic send1(input logic [W-1:0] w);
    int n = 0;
    b1.word_in = w; b1.word_valid = 1'b1;
    while (!b1.word_ready && n < 100) begin @(negedge clk); n++; end
    chk("send1.ready", 32'(b1.word_ready), 32'd1);
    @(negedge clk);
    b1.word_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] pat;
    logic p1, p2, cb, det;
    int n;
    b0.word_valid = 1'b0; b0.word_in = '0;
    b1.word_valid = 1'b0; b1.word_in = '0;

    #1 rst = 1'b1;
    #1;
    chk("rst.ready0", 32'(b0.word_ready), 32'd1);
    chk("rst.bv0",    32'(b0.bit_valid),  32'd0);
    chk("rst.fs0",    32'(b0.frame_start), 32'd0);
    chk("rst.busy0",  32'(b0.busy),       32'd0);
    chk("rst.bo0",    32'(b0.bit_out),    32'd0);
    chk("rst.ws0",    32'(b0.words_sent), 32'd0);
    chk("rst.bo1",    32'(b1.bit_out),    32'd1);
    chk("rst.ws1",    32'(b1.words_sent), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single word MSB-first.
    pat = 8'hA5;
    send0(pat);
    for (int c = 1; c <= 8; c++) begin
      chk("a5.bit", 32'(b0.bit_out), 32'(pat[8-c]));
      chk("a5.vld", 32'(b0.bit_valid), 32'd1);
      chk("a5.fs",  32'(b0.frame_start), 32'(c == 1));
      @(negedge clk);
    end
    chk("a5.after_vld", 32'(b0.bit_valid), 32'd0);
    chk("a5.sent",      32'(b0.words_sent), 32'd1);

    // Single word LSB-first, idle-high line.
    send1(8'h01);
    for (int c = 1; c <= 8; c++) begin
      chk("lsb01.bit", 32'(b1.bit_out), 32'(c == 1));
      @(negedge clk);
    end
    chk("lsb01.idle_bit", 32'(b1.bit_out), 32'd1);
    chk("lsb01.idle_vld", 32'(b1.bit_valid), 32'd0);

    // Back-to-back through the hold register.
    send0(8'hA5);
    chk("b2b.fs1", 32'(b0.frame_start), 32'd1);
    send0(8'h5A);
    chk("b2b.ready_low", 32'(b0.word_ready), 32'd0);
    for (int c = 2; c <= 16; c++) begin
      chk("b2b.vld", 32'(b0.bit_valid), 32'd1);
      chk("b2b.fs",  32'(b0.frame_start), 32'(c == 9));
      @(negedge clk);
    end
    chk("b2b.end_vld", 32'(b0.bit_valid), 32'd0);
    chk("b2b.sent",    32'(b0.words_sent), 32'd3);

    // Overlapping 101 detection on the serial line.
    p1 = 1'b0; p2 = 1'b0;
    send0(8'b1010_1000);
    for (int c = 1; c <= 12; c++) begin
      cb  = b0.bit_out;
      det = p2 && !p1 && cb;
      chk("det101", 32'(det), 32'(c == 3 || c == 5));
      p2 = p1; p1 = cb;
      @(negedge clk);
    end

    // Reset during bit 4 with a word held.
    send0(8'hFF);
    send0(8'h0F);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst.bv",    32'(b0.bit_valid),  32'd0);
    chk("mrst.busy",  32'(b0.busy),       32'd0);
    chk("mrst.ws",    32'(b0.words_sent), 32'd0);
    chk("mrst.ready", 32'(b0.word_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send0(8'hC3);
    chk("mrst.first_bit", 32'(b0.bit_out), 32'd1);
    chk("mrst.first_fs",  32'(b0.frame_start), 32'd1);

    // 4-bit counter wrap over 17 words.
    seen15 = 1'b0; seenwrap = 1'b0;
    for (int k = 0; k < 17; k++) send1(W'($urandom));
    n = 0;
    while (b1.busy && n < 40) begin @(negedge clk); n++; end
    chk("wrap.drained", 32'(b1.busy), 32'd0);
    chk("wrap.ws",      32'(b1.words_sent), 32'd1);
    chk("wrap.seen15",  32'(seen15), 32'd1);
    chk("wrap.seen0",   32'(seenwrap), 32'd1);

    // Random traffic; the compare process does the checking.
    repeat (500) begin
      @(negedge clk);
      b0.word_valid = ($urandom % 3) != 0;
      b0.word_in    = W'($urandom);
      b1.word_valid = ($urandom % 2) != 0;
      b1.word_in    = W'($urandom);
    end
    @(negedge clk);
    b0.word_valid = 1'b0; b1.word_valid = 1'b0;
    repeat (24) @(negedge clk);
    chk("end.idle0", 32'(b0.busy), 32'd0);
    chk("end.idle1", 32'(b1.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
